// File: rtl/buart_ext_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : buart_ext_if                                                |
// | Purpose  : CPU-side bus bundle for the buart_ext serial transceiver.   |
// | Signals  : wr/tx_data push into the TX FIFO, rd pops the RX FIFO,      |
// |            rx_data/valid show the RX head, busy/tx_full report TX      |
// |            state, clr_err clears overrun/frame_err/parity_err.         |
// | Modports : master = CPU side, slave = transceiver side.                |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
interface buart_ext_if #(
  parameter int DATA_BITS = 8
);
  logic                 wr;
  logic [DATA_BITS-1:0] tx_data;
  logic                 rd;
  logic [DATA_BITS-1:0] rx_data;
  logic                 valid;
  logic                 busy;
  logic                 tx_full;
  logic                 clr_err;
  logic                 overrun;
  logic                 frame_err;
  logic                 parity_err;

  modport master (
    output wr, tx_data, rd, clr_err,
    input  rx_data, valid, busy, tx_full, overrun, frame_err, parity_err
  );

  modport slave (
    input  wr, tx_data, rd, clr_err,
    output rx_data, valid, busy, tx_full, overrun, frame_err, parity_err
  );
endinterface
`default_nettype wire

// File: rtl/buart_ext.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : buart_ext                                                   |
// | Purpose  : Full-duplex UART with configurable data width, parity and   |
// |            stop bits, TX/RX FIFOs and sticky receive error flags.      |
// | Ports    : clk     - single clock                                      |
// |            resetq  - asynchronous active-low reset                     |
// |            tx      - serial output, idle high                          |
// |            rx      - serial input, asynchronous to clk                 |
// |            bus     - buart_ext_if.slave CPU-side bundle                |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module buart_ext #(
  parameter int FREQ_HZ   = 6000000,
  parameter int BAUDS     = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int TX_DEPTH  = 4,
  parameter int RX_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       resetq,
  output logic       tx,
  input  logic       rx,
  buart_ext_if.slave bus
);
  localparam int C_DIV   = FREQ_HZ / BAUDS;
  localparam int C_PB    = (PARITY != 0) ? 1 : 0;
  localparam int C_FRAME = 1 + DATA_BITS + C_PB + STOP_BITS;
  localparam int C_CW    = $clog2(C_DIV);
  localparam int C_TAW   = $clog2(TX_DEPTH);
  localparam int C_RAW   = $clog2(RX_DEPTH);
  localparam logic [C_CW-1:0] C_BIT_LAST  = C_CW'(C_DIV - 1);
  localparam logic [C_CW-1:0] C_HALF_LAST = C_CW'(C_DIV / 2 - 1);
  localparam logic [2:0]      C_LAST_DBIT = 3'(DATA_BITS - 1);

  localparam logic [0:0] C_TX_IDLE   = 1'b0;
  localparam logic [0:0] C_TX_SHIFT  = 1'b1;
  localparam logic [2:0] C_RX_IDLE   = 3'd0;
  localparam logic [2:0] C_RX_START  = 3'd1;
  localparam logic [2:0] C_RX_DATA   = 3'd2;
  localparam logic [2:0] C_RX_PARITY = 3'd3;
  localparam logic [2:0] C_RX_STOP   = 3'd4;

  // Odd parity makes the total count of ones odd, even makes it even.
  function automatic logic par_bit(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~^d : ^d;
  endfunction

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] r_tx_mem [TX_DEPTH];
  logic [C_TAW:0]       r_tx_wp, r_tx_rp;
  logic                 w_tx_empty, w_tx_full, w_tx_push, w_tx_load;
  logic [DATA_BITS-1:0] w_tx_head;

  assign w_tx_empty = (r_tx_wp == r_tx_rp);
  assign w_tx_full  = (r_tx_wp[C_TAW] != r_tx_rp[C_TAW]) &&
                      (r_tx_wp[C_TAW-1:0] == r_tx_rp[C_TAW-1:0]);
  // A full FIFO still accepts a write when the shifter pops in the same cycle.
  assign w_tx_push  = bus.wr && (!w_tx_full || w_tx_load);
  assign w_tx_head  = r_tx_mem[r_tx_rp[C_TAW-1:0]];
  assign bus.tx_full = w_tx_full;

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp[C_TAW-1:0]] <= bus.tx_data;
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_tx_wp <= '0;
      r_tx_rp <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
      if (w_tx_load) r_tx_rp <= r_tx_rp + 1'b1;
    end
  end

  // ---------------- TX FSM ----------------
  logic [0:0]         r_tx_state, w_tx_next;
  logic [C_CW-1:0]    r_tx_cnt;
  logic [3:0]         r_tx_bits;
  logic [C_FRAME-2:0] r_tx_sr;
  logic [C_FRAME-1:0] w_tx_frame;
  logic               r_tx;
  logic               w_tx_bit_end, w_tx_frame_end;

  assign w_tx_bit_end   = (r_tx_cnt == '0);
  assign w_tx_frame_end = w_tx_bit_end && (r_tx_bits == 4'd0);
  assign tx             = r_tx;

  always_comb begin
    w_tx_frame               = '1;
    w_tx_frame[0]            = 1'b0;
    w_tx_frame[DATA_BITS:1]  = w_tx_head;
    if (C_PB != 0) w_tx_frame[DATA_BITS+1] = par_bit(w_tx_head);
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) r_tx_state <= C_TX_IDLE;
    else         r_tx_state <= w_tx_next;
  end

  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      C_TX_IDLE:  if (!w_tx_empty) w_tx_next = C_TX_SHIFT;
      C_TX_SHIFT: if (w_tx_frame_end && w_tx_empty) w_tx_next = C_TX_IDLE;
      default:    w_tx_next = C_TX_IDLE;
    endcase
  end

  // Reloading straight out of the last stop bit keeps frames contiguous.
  always_comb begin
    w_tx_load = 1'b0;
    bus.busy  = !w_tx_empty || (r_tx_state == C_TX_SHIFT);
    if (!w_tx_empty) begin
      if (r_tx_state == C_TX_IDLE) w_tx_load = 1'b1;
      else if (w_tx_frame_end)     w_tx_load = 1'b1;
    end
  end

  // The start bit goes out on the load edge; the shifter holds the rest.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_tx      <= 1'b1;
      r_tx_sr   <= '1;
      r_tx_cnt  <= '0;
      r_tx_bits <= 4'd0;
    end else if (w_tx_load) begin
      r_tx      <= 1'b0;
      r_tx_sr   <= w_tx_frame[C_FRAME-1:1];
      r_tx_cnt  <= C_BIT_LAST;
      r_tx_bits <= 4'(C_FRAME - 1);
    end else if (r_tx_state == C_TX_SHIFT) begin
      if (!w_tx_bit_end) begin
        r_tx_cnt <= r_tx_cnt - 1'b1;
      end else if (r_tx_bits != 4'd0) begin
        r_tx      <= r_tx_sr[0];
        r_tx_sr   <= {1'b1, r_tx_sr[C_FRAME-2:1]};
        r_tx_bits <= r_tx_bits - 1'b1;
        r_tx_cnt  <= C_BIT_LAST;
      end else begin
        r_tx <= 1'b1;
      end
    end
  end

  // ---------------- RX synchroniser and FSM ----------------
  logic                 r_rx_s1, r_rx_s2;
  logic [2:0]           r_rx_state, w_rx_next;
  logic [C_CW-1:0]      r_rx_cnt;
  logic [2:0]           r_rx_bits;
  logic [DATA_BITS-1:0] r_rx_sr;
  logic                 r_rx_par;
  logic                 w_rx_tick, w_rx_done, w_rx_perr, w_rx_ferr;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
    end
  end

  assign w_rx_tick = (r_rx_cnt == '0);

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) r_rx_state <= C_RX_IDLE;
    else         r_rx_state <= w_rx_next;
  end

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      C_RX_IDLE:   if (!r_rx_s2) w_rx_next = C_RX_START;
      C_RX_START:  if (w_rx_tick) w_rx_next = r_rx_s2 ? C_RX_IDLE : C_RX_DATA;
      C_RX_DATA:   if (w_rx_tick && (r_rx_bits == C_LAST_DBIT))
                     w_rx_next = (C_PB != 0) ? C_RX_PARITY : C_RX_STOP;
      C_RX_PARITY: if (w_rx_tick) w_rx_next = C_RX_STOP;
      C_RX_STOP:   if (w_rx_tick) w_rx_next = C_RX_IDLE;
      default:     w_rx_next = C_RX_IDLE;
    endcase
  end

  // The frame is finished at the first stop-bit sample; a second stop bit
  // simply looks like idle line to the next IDLE state.
  always_comb begin
    w_rx_done = (r_rx_state == C_RX_STOP) && w_rx_tick;
    w_rx_ferr = w_rx_done && !r_rx_s2;
    w_rx_perr = w_rx_done && (C_PB != 0) && (r_rx_par != par_bit(r_rx_sr));
  end

  // Counter idles at half a bit so the START check lands mid-bit.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_rx_cnt  <= '0;
      r_rx_bits <= 3'd0;
      r_rx_sr   <= '0;
      r_rx_par  <= 1'b0;
    end else if (r_rx_state == C_RX_IDLE) begin
      r_rx_cnt  <= C_HALF_LAST;
      r_rx_bits <= 3'd0;
    end else if (!w_rx_tick) begin
      r_rx_cnt <= r_rx_cnt - 1'b1;
    end else begin
      r_rx_cnt <= C_BIT_LAST;
      if (r_rx_state == C_RX_DATA) begin
        r_rx_sr   <= {r_rx_s2, r_rx_sr[DATA_BITS-1:1]};
        r_rx_bits <= r_rx_bits + 1'b1;
      end
      if (r_rx_state == C_RX_PARITY) r_rx_par <= r_rx_s2;
    end
  end

  // ---------------- RX FIFO and sticky flags ----------------
  logic [DATA_BITS-1:0] r_rx_mem [RX_DEPTH];
  logic [C_RAW:0]       r_rx_wp, r_rx_rp;
  logic                 w_rx_empty, w_rx_full, w_rx_push, w_rx_pop, w_ovr;
  logic                 r_ovr, r_ferr, r_perr;

  assign w_rx_empty = (r_rx_wp == r_rx_rp);
  assign w_rx_full  = (r_rx_wp[C_RAW] != r_rx_rp[C_RAW]) &&
                      (r_rx_wp[C_RAW-1:0] == r_rx_rp[C_RAW-1:0]);
  assign w_rx_pop   = bus.rd && !w_rx_empty;
  assign w_rx_push  = w_rx_done && (!w_rx_full || w_rx_pop);
  assign w_ovr      = w_rx_done && w_rx_full && !w_rx_pop;

  assign bus.valid      = !w_rx_empty;
  assign bus.rx_data    = w_rx_empty ? '0 : r_rx_mem[r_rx_rp[C_RAW-1:0]];
  assign bus.overrun    = r_ovr;
  assign bus.frame_err  = r_ferr;
  assign bus.parity_err = r_perr;

  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wp[C_RAW-1:0]] <= r_rx_sr;
  end

  // A new error outranks clr_err in the same cycle.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_rx_wp <= '0;
      r_rx_rp <= '0;
      r_ovr   <= 1'b0;
      r_ferr  <= 1'b0;
      r_perr  <= 1'b0;
    end else begin
      if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
      if (w_ovr)            r_ovr  <= 1'b1;
      else if (bus.clr_err) r_ovr  <= 1'b0;
      if (w_rx_ferr)        r_ferr <= 1'b1;
      else if (bus.clr_err) r_ferr <= 1'b0;
      if (w_rx_perr)        r_perr <= 1'b1;
      else if (bus.clr_err) r_perr <= 1'b0;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_buart_ext.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_buart_ext                                                |
// | Purpose  : Directed self-checking bench for buart_ext. Instance a is   |
// |            8N1, instance b is even parity with two stop bits; both     |
// |            run at 16 clocks per bit with 4-entry FIFOs.                |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module tb_buart_ext;
  localparam int DIV = 16;

  logic clk    = 1'b0;
  logic resetq = 1'b0;
  logic tx_a, tx_b;
  logic ser_a  = 1'b1;
  logic ser_b  = 1'b1;
  logic loop_a = 1'b0;
  logic rx_a;

  assign rx_a = loop_a ? tx_a : ser_a;

  always #5 clk = ~clk;

  buart_ext_if #(.DATA_BITS(8)) bus_a ();
  buart_ext_if #(.DATA_BITS(8)) bus_b ();

  buart_ext #(
    .FREQ_HZ(160000), .BAUDS(10000), .DATA_BITS(8), .PARITY(0),
    .STOP_BITS(1), .TX_DEPTH(4), .RX_DEPTH(4)
  ) u_a (
    .clk(clk), .resetq(resetq), .tx(tx_a), .rx(rx_a), .bus(bus_a)
  );

  buart_ext #(
    .FREQ_HZ(160000), .BAUDS(10000), .DATA_BITS(8), .PARITY(2),
    .STOP_BITS(2), .TX_DEPTH(4), .RX_DEPTH(4)
  ) u_b (
    .clk(clk), .resetq(resetq), .tx(tx_b), .rx(ser_b), .bus(bus_b)
  );

  int n_total = 0;
  int n_bad   = 0;
  logic tx_log [1000];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive a frame (LSB first) on the selected serial line, one bit per DIV
  // clocks; rd on bus a is high only for the posedge numbered rd_edge.
  task automatic send(input int sel, input logic [15:0] fr, input int nb, input int rd_edge);
    for (int c = 0; c < nb * DIV; c++) begin
      @(negedge clk);
      if (sel == 0) ser_a = fr[c / DIV];
      else          ser_b = fr[c / DIV];
      bus_a.rd = ((c + 1) == rd_edge);
    end
    bus_a.rd = 1'b0;
  endtask

  task automatic drive(input int sel, input logic v, input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (sel == 0) ser_a = v;
      else          ser_b = v;
    end
  endtask

  task automatic send8n1(input logic [7:0] d, input int rd_edge);
    send(0, {6'b0, 1'b1, d, 1'b0}, 10, rd_edge);
  endtask

  task automatic pop_chk(input int sel, input string tag, input logic [7:0] exp);
    @(negedge clk);
    if (sel == 0) begin
      chk({tag, "_valid"}, bus_a.valid, 1);
      chk(tag, bus_a.rx_data, exp);
      bus_a.rd = 1'b1;
      @(negedge clk);
      bus_a.rd = 1'b0;
    end else begin
      chk({tag, "_valid"}, bus_b.valid, 1);
      chk(tag, bus_b.rx_data, exp);
      bus_b.rd = 1'b1;
      @(negedge clk);
      bus_b.rd = 1'b0;
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    bus_a.clr_err = 1'b1;
    bus_b.clr_err = 1'b1;
    @(negedge clk);
    bus_a.clr_err = 1'b0;
    bus_b.clr_err = 1'b0;
  endtask

  initial begin
    int nbusy;
    logic full_log [6];

    bus_a.wr = 1'b0; bus_a.tx_data = 8'h00; bus_a.rd = 1'b0; bus_a.clr_err = 1'b0;
    bus_b.wr = 1'b0; bus_b.tx_data = 8'h00; bus_b.rd = 1'b0; bus_b.clr_err = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx", tx_a, 1);
    chk("rst_busy", bus_a.busy, 0);
    chk("rst_full", bus_a.tx_full, 0);
    chk("rst_valid", bus_a.valid, 0);
    chk("rst_rxdata", bus_a.rx_data, 0);
    chk("rst_flags", {bus_a.overrun, bus_a.frame_err, bus_a.parity_err}, 0);
    resetq = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1 loopback, three back-to-back writes
    loop_a = 1'b1;
    bus_a.wr = 1'b1; bus_a.tx_data = 8'h55;
    nbusy = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      tx_log[i] = tx_a;
      if (bus_a.busy) nbusy++;
      if (i == 0)      bus_a.tx_data = 8'hA3;
      else if (i == 1) bus_a.tx_data = 8'h00;
      else if (i == 2) bus_a.wr = 1'b0;
    end
    chk("lb_busy_len", nbusy, 481);
    chk("lb_tx_pre", tx_log[0], 1);
    chk("lb_tx_start", tx_log[1], 0);
    chk("lb_tx_b0", tx_log[17], 1);
    chk("lb_tx_b1", tx_log[33], 0);
    chk("lb_tx_stop1", tx_log[160], 1);
    chk("lb_tx_start2", tx_log[161], 0);
    chk("lb_tx_start3", tx_log[321], 0);
    chk("lb_tx_idle", tx_log[481], 1);
    pop_chk(0, "lb_d0", 8'h55);
    pop_chk(0, "lb_d1", 8'hA3);
    pop_chk(0, "lb_d2", 8'h00);
    @(negedge clk);
    chk("lb_empty", bus_a.valid, 0);
    chk("lb_flags", {bus_a.overrun, bus_a.frame_err, bus_a.parity_err}, 0);
    loop_a = 1'b0;

    // Even parity, two stop bits: 0x81 has two ones, so parity bit is 0
    send(1, {4'b0, 2'b11, 1'b0, 8'h81, 1'b0}, 12, 0);
    pop_chk(1, "par_ok", 8'h81);
    chk("par_ok_flag", bus_b.parity_err, 0);
    send(1, {4'b0, 2'b11, 1'b1, 8'h81, 1'b0}, 12, 0);
    pop_chk(1, "par_bad", 8'h81);
    chk("par_bad_flag", bus_b.parity_err, 1);
    chk("par_bad_ferr", bus_b.frame_err, 0);
    pulse_clr();
    chk("par_clr", bus_b.parity_err, 0);

    // Framing error: stop bit held low past its mid-bit sample
    send(0, {7'b0, 8'h3C, 1'b0}, 9, 0);
    drive(0, 1'b0, DIV / 2 + 4);
    drive(0, 1'b1, 3 * DIV);
    pop_chk(0, "ferr_data", 8'h3C);
    chk("ferr_flag", bus_a.frame_err, 1);
    // Short glitch is a false start
    drive(0, 1'b0, 3);
    drive(0, 1'b1, 3 * DIV);
    chk("glitch_nopush", bus_a.valid, 0);
    send8n1(8'hC3, 0);
    drive(0, 1'b1, 4);
    pop_chk(0, "after_glitch", 8'hC3);
    pulse_clr();
    chk("ferr_clr", bus_a.frame_err, 0);

    // Overrun: five frames into a 4-deep FIFO
    send8n1(8'h11, 0); send8n1(8'h22, 0); send8n1(8'h33, 0);
    send8n1(8'h44, 0); send8n1(8'h55, 0);
    drive(0, 1'b1, 4);
    chk("ovr_set", bus_a.overrun, 1);
    pop_chk(0, "ovr_d0", 8'h11);
    pop_chk(0, "ovr_d1", 8'h22);
    pop_chk(0, "ovr_d2", 8'h33);
    pop_chk(0, "ovr_d3", 8'h44);
    @(negedge clk);
    chk("ovr_dropped", bus_a.valid, 0);
    pulse_clr();
    chk("ovr_clr", bus_a.overrun, 0);
    // Same again, with rd on the fifth push edge (E155 of the frame)
    send8n1(8'h11, 0); send8n1(8'h22, 0); send8n1(8'h33, 0);
    send8n1(8'h44, 0); send8n1(8'h55, 155);
    drive(0, 1'b1, 4);
    chk("ovr_rd_none", bus_a.overrun, 0);
    pop_chk(0, "ovr_rd_d0", 8'h22);
    pop_chk(0, "ovr_rd_d1", 8'h33);
    pop_chk(0, "ovr_rd_d2", 8'h44);
    pop_chk(0, "ovr_rd_d3", 8'h55);
    @(negedge clk);
    chk("ovr_rd_empty", bus_a.valid, 0);

    // TX full: six consecutive writes, five frames expected
    bus_a.wr = 1'b1; bus_a.tx_data = 8'h01;
    nbusy = 0;
    for (int i = 0; i < 900; i++) begin
      @(negedge clk);
      if (i < 6) full_log[i] = bus_a.tx_full;
      if (bus_a.busy) nbusy++;
      if (i < 5)       bus_a.tx_data = 8'(i + 2);
      else if (i == 5) bus_a.wr = 1'b0;
    end
    chk("full_after4", full_log[3], 0);
    chk("full_after5", full_log[4], 1);
    chk("full_after6", full_log[5], 1);
    chk("full_frames", nbusy, 801);
    chk("full_clear", bus_a.tx_full, 0);

    // Reset in the middle of a frame, with overrun and RX data pending
    send8n1(8'h01, 0); send8n1(8'h02, 0); send8n1(8'h03, 0);
    send8n1(8'h04, 0); send8n1(8'h05, 0);
    drive(0, 1'b1, 4);
    chk("pre_rst_ovr", bus_a.overrun, 1);
    bus_a.wr = 1'b1; bus_a.tx_data = 8'hA5;
    @(negedge clk);
    bus_a.wr = 1'b0;
    repeat (50) @(negedge clk);
    chk("pre_rst_busy", bus_a.busy, 1);
    #2 resetq = 1'b0;
    #1;
    chk("mid_rst_tx", tx_a, 1);
    chk("mid_rst_busy", bus_a.busy, 0);
    @(negedge clk);
    resetq = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_valid", bus_a.valid, 0);
    chk("post_rst_flags", {bus_a.overrun, bus_a.frame_err, bus_a.parity_err}, 0);
    chk("post_rst_tx", tx_a, 1);
    chk("post_rst_busy", bus_a.busy, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
